icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the CPU fetch port and a slower backing memory.
//  CPU-side address/data pair the CPU's fetch address and fetched instruction; the block stalls the CPU through its clock enable on a miss.
//  On a miss it fetches one full line from the backing memory using a request/ack handshake followed by sequential data beats.
// PARAMETERS
//  LINE_WORDS  4   32-bit words per line; power of 2, >=2
//  LINES       64  number of lines; power of 2 (64x4 words = 1 KiB)
// PORTS
//  i_clk        in   1   clock; sole clock domain
//  i_rst        in   1   reset, synchronous, active-high
//  i_ce         in   1   global clock enable from top level
//  i_flush      in   1   invalidate all lines (fence.i); single-cycle pulse
//  i_addr       in   32  CPU fetch address; bits [1:0] ignored
//  o_data       out  32  instruction word; valid when o_cpu_ce=1
//  o_cpu_ce     out  1   clock enable to CPU; 0 = CPU stalled
//  o_mem_req    out  1   line-fill request to backing memory
//  o_mem_addr   out  32  line-aligned fill address
//  i_mem_ack    in   1   request accepted (1-cycle pulse)
//  i_mem_valid  in   1   fill data beat valid
//  i_mem_data   in   32  fill data beat
// BEHAVIOUR
//  Address split: OFF=2+log2(LINE_WORDS), IDX=log2(LINES); word=i_addr[OFF-1:2], index=i_addr[OFF+IDX-1:OFF], tag=i_addr[31:OFF+IDX].
//  Lookup is combinational: hit = valid[index] & tag match; o_data = data[index][word] when hit, else 0.
//  o_cpu_ce = i_ce & (state==IDLE) & hit & !i_flush. Hits are zero-wait: data appears in the same cycle as i_addr.
//  FSM states: IDLE, REQ, FILL, DONE. The FSM advances independently of i_ce.
//   IDLE -> REQ on (i_ce & !hit & !i_flush); o_mem_addr latched = {i_addr[31:OFF], OFF'b0}.
//   REQ: o_mem_req=1 and o_mem_addr held stable until i_mem_ack=1 -> FILL. A beat coinciding with ack is invalid (protocol).
//   FILL: each i_mem_valid writes i_mem_data to word cnt and increments cnt (0..LINE_WORDS-1, critical word not first).
//     The last beat writes the tag, sets valid[index] unless flush_pending, -> DONE.
//   DONE: 1 cycle; applies a pending flush (clears all valid bits, clears flush_pending) -> IDLE. The lookup then hits, so the CPU resumes the next cycle.
//  Miss penalty with zero-wait memory: 1 (IDLE) + 1 (REQ) + LINE_WORDS (FILL) + 1 (DONE) cycles.
//  Flush:
//   In IDLE: clears all valid bits at the clock edge; o_cpu_ce=0 that cycle.
//   In REQ/FILL: sets flush_pending. The bus transaction always completes, but the filled line is not validated.
//  Reset values: state=IDLE, valid[*]=0, cnt=0, flush_pending=0, o_mem_req=0, o_mem_addr=0, o_cpu_ce=0, o_data=0. Data/tag arrays are not reset.
//  Reset mid-fill: the FSM returns to IDLE immediately. Backing memory shares i_rst, so it drops its transaction. Stray i_mem_valid seen in IDLE/REQ is ignored.
//  i_ce low during a miss: the fill still proceeds; o_cpu_ce stays 0 until i_ce returns.
//  i_addr changing during a fill: ignored; after DONE the new address is looked up (and may miss again).
// STRUCTURE
//  Shared header cache_defs.vh (`include): FSM state localparams, CLOG2 macro, address-split helpers shared with a future dcache.
//  Sub-module icache_ram: tag+data storage with a combinational read port and a synchronous write port (tag, index, word, data, we, tag_we).
//  The valid bit vector lives in icache itself (flops) so that a flush clears it in one cycle.
// TESTING
//  1 Reset, fetch 0x0 -> o_mem_req=1, o_mem_addr=0x0. Ack, then beats 0x13,0x01,0x02,0x03 -> o_cpu_ce=1, o_data=0x13. i_addr=0x8 hits: o_data=0x02.
//  2 After test 1, fetch 0x400 (same index 0) -> miss, refill with o_mem_addr=0x400; a subsequent fetch of 0x0 misses again.
//  3 Flush pulse in IDLE with line 0 cached -> fetch 0x0 gives o_cpu_ce=0 and o_mem_req=1.
//  4 Flush on beat 2 of a fill -> all 4 beats accepted, DONE, fetch of the same line misses again. No extra request is issued before IDLE.
//  5 i_rst on beat 2 of a fill -> next cycle o_mem_req=0, o_cpu_ce=0, all valid bits=0. Remaining beats are ignored.
//  6 Hold i_mem_ack=0 for 5 cycles in REQ -> o_mem_req=1, o_mem_addr stable, o_cpu_ce=0 throughout. Miss-to-resume latency = 3+LINE_WORDS+stall cycles.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: fill FSM states and address helpers.
package icache_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE
    } state_t;

    // Clears the byte/word offset bits so the address points at the start of its line.
    function automatic logic [XLEN-1:0] line_base(input logic [XLEN-1:0] addr, input int off);
        logic [XLEN-1:0] mask;
        mask = {XLEN{1'b1}} << off;
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_ram.sv
// Tag and data storage for the instruction cache: combinational read, synchronous write.
module icache_ram #(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64,
    parameter int WORD_W     = 2,
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 22
) (
    input  logic              i_clk,
    input  logic [IDX_W-1:0]  i_rd_index,
    input  logic [WORD_W-1:0] i_rd_word,
    output logic [31:0]       o_rd_data,
    output logic [TAG_W-1:0]  o_rd_tag,
    input  logic [IDX_W-1:0]  i_wr_index,
    input  logic [WORD_W-1:0] i_wr_word,
    input  logic [31:0]       i_wr_data,
    input  logic              i_we,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic              i_tag_we
);

    logic [31:0]      data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];

    // NOTE: storage arrays carry no reset; the valid bits in the parent gate every read, so their power-up contents never escape.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            data_mem[{i_wr_index, i_wr_word}] <= i_wr_data;
        end
        if (i_tag_we) begin
            tag_mem[i_wr_index] <= i_wr_tag;
        end
    end

    assign o_rd_data = data_mem[{i_rd_index, i_rd_word}];
    assign o_rd_tag  = tag_mem[i_rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-wait hits, stalls the CPU while a line is refilled.
module icache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_flush,
    input  logic [31:0] i_addr,
    output logic [31:0] o_data,
    output logic        o_cpu_ce,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_data
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF    = 2 + WORD_W;
    localparam int TAG_W  = XLEN - OFF - IDX_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    state_t            state;
    logic [WORD_W-1:0] cnt;
    logic              flush_pending;
    logic [LINES-1:0]  valid;

    logic [WORD_W-1:0] rd_word;
    logic [IDX_W-1:0]  rd_index;
    logic [TAG_W-1:0]  rd_tag;
    logic [IDX_W-1:0]  fill_index;
    logic [TAG_W-1:0]  fill_tag;
    logic [31:0]       ram_data;
    logic [TAG_W-1:0]  ram_tag;
    logic              hit;
    logic              fill_we;
    logic              last_beat;
    logic              unused_bits;

    assign rd_word    = i_addr[OFF-1:2];
    assign rd_index   = i_addr[OFF+IDX_W-1:OFF];
    assign rd_tag     = i_addr[31:OFF+IDX_W];
    assign fill_index = o_mem_addr[OFF+IDX_W-1:OFF];
    assign fill_tag   = o_mem_addr[31:OFF+IDX_W];
    assign unused_bits = ^{i_addr[1:0], o_mem_addr[OFF-1:0]};

    assign hit       = valid[rd_index] && (ram_tag == rd_tag);
    assign fill_we   = (state == S_FILL) && i_mem_valid;
    assign last_beat = (cnt == LAST_WORD);

    icache_ram #(
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES),
        .WORD_W     (WORD_W),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_ram (
        .i_clk      (i_clk),
        .i_rd_index (rd_index),
        .i_rd_word  (rd_word),
        .o_rd_data  (ram_data),
        .o_rd_tag   (ram_tag),
        .i_wr_index (fill_index),
        .i_wr_word  (cnt),
        .i_wr_data  (i_mem_data),
        .i_we       (fill_we),
        .i_wr_tag   (fill_tag),
        .i_tag_we   (fill_we && last_beat)
    );

    always_comb begin
        // NOTE: every output gets a default before the conditions so no path leaves it unassigned.
        o_data   = '0;
        o_cpu_ce = 1'b0;
        if (hit) begin
            o_data = ram_data;
        end
        if (i_ce && (state == S_IDLE) && hit && !i_flush) begin
            o_cpu_ce = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            flush_pending <= 1'b0;
            valid         <= '0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_flush) begin
                        valid <= '0;
                    end else if (i_ce && !hit) begin
                        // The victim line is invalidated up front since its words get overwritten.
                        valid[rd_index] <= 1'b0;
                        o_mem_addr      <= line_base(i_addr, OFF);
                        o_mem_req       <= 1'b1;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (i_mem_valid) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            if (!(flush_pending || i_flush)) begin
                                valid[fill_index] <= 1'b1;
                            end
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush_pending || i_flush) begin
                        valid <= '0;
                    end
                    flush_pending <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios then randomized fetches against a line-map model.
module tb_icache;

    localparam int LW         = 4;
    localparam int NL         = 64;
    localparam int LINE_BYTES = 4 * LW;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ce;
    logic        i_flush;
    logic [31:0] i_addr;
    logic [31:0] o_data;
    logic        o_cpu_ce;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;

    always #5 i_clk = ~i_clk;

    icache #(
        .LINE_WORDS (LW),
        .LINES      (NL)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ce        (i_ce),
        .i_flush     (i_flush),
        .i_addr      (i_addr),
        .o_data      (o_data),
        .o_cpu_ce    (o_cpu_ce),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_valid (i_mem_valid),
        .i_mem_data  (i_mem_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Backing memory contents (lazily randomized, then fixed) and the cache model:
    // index -> line base address currently cached there.
    logic [31:0] bmem   [logic [31:0]];
    logic [31:0] m_line [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'h3;
        if (!bmem.exists(wa)) bmem[wa] = $urandom;
        return bmem[wa];
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & ~32'(LINE_BYTES - 1);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % NL);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_line.exists(idx_of(a)) && (m_line[idx_of(a)] == base_of(a));
    endfunction

    task automatic flush_idle(input logic [31:0] addr);
        @(negedge i_clk);
        i_addr  = addr;
        i_ce    = 1'b1;
        i_flush = 1'b1;
        #1;
        check("flush_ce", o_cpu_ce, 0);
        @(negedge i_clk);
        i_flush = 1'b0;
        i_ce    = 1'b0;
        #1;
        check("flush_noreq", o_mem_req, 0);
        m_line.delete();
    endtask

    // One CPU fetch; on a miss the bench plays the backing memory.
    // flush_beat / rst_beat < 0 disable those events; drop_ce lowers i_ce for the whole fill.
    task automatic fetch(input logic [31:0] addr, input int ack_delay, input int max_gap,
                         input int flush_beat, input int rst_beat, input bit drop_ce);
        logic [31:0] base;
        int          cycles;
        int          gaps;
        int          g;
        base = base_of(addr);
        @(negedge i_clk);
        i_addr = addr;
        i_ce   = 1'b1;
        #1;
        if (m_hit(addr)) begin
            check("hit_ce", o_cpu_ce, 1);
            check("hit_data", o_data, mem_word(addr));
            i_ce = 1'b0;
            return;
        end
        check("miss_ce", o_cpu_ce, 0);
        cycles = 0;
        gaps   = 0;
        for (int d = 0; d <= ack_delay; d++) begin
            @(negedge i_clk);
            cycles++;
            if (drop_ce) i_ce = 1'b0;
            i_mem_ack = (d == ack_delay);
            #1;
            check("req", o_mem_req, 1);
            check("req_addr", o_mem_addr, base);
            check("stall_ce", o_cpu_ce, 0);
        end
        for (int b = 0; b < LW; b++) begin
            g = int'($urandom_range(max_gap));
            repeat (g) begin
                @(negedge i_clk);
                cycles++;
                gaps++;
                i_mem_ack   = 1'b0;
                i_mem_valid = 1'b0;
                i_flush     = 1'b0;
                i_mem_data  = $urandom;
            end
            @(negedge i_clk);
            cycles++;
            i_mem_ack   = 1'b0;
            i_mem_valid = 1'b1;
            i_mem_data  = mem_word(base + 32'(4 * b));
            i_flush     = (b == flush_beat);
            i_rst       = (b == rst_beat);
            if (b == rst_beat) begin
                m_line.delete();
                for (int r = b + 1; r < LW; r++) begin
                    @(negedge i_clk);
                    i_rst       = 1'b0;
                    i_mem_valid = 1'b1;
                    i_mem_data  = mem_word(base + 32'(4 * r));
                    i_ce        = 1'b1;
                    #1;
                    check("rst_req", o_mem_req, 0);
                    check("rst_ce", o_cpu_ce, 0);
                    i_ce = 1'b0;
                end
                @(negedge i_clk);
                i_rst       = 1'b0;
                i_mem_valid = 1'b0;
                #1;
                check("rst_idle_req", o_mem_req, 0);
                return;
            end
        end
        @(negedge i_clk);
        cycles++;
        i_mem_valid = 1'b0;
        i_flush     = 1'b0;
        #1;
        check("done_ce", o_cpu_ce, 0);
        check("done_req", o_mem_req, 0);
        if (flush_beat >= 0) m_line.delete();
        else m_line[idx_of(addr)] = base;
        @(negedge i_clk);
        cycles++;
        #1;
        check("resume_req", o_mem_req, 0);
        if (drop_ce) begin
            check("ce_low", o_cpu_ce, 0);
            i_ce = 1'b1;
            #1;
        end
        check("resume_ce", o_cpu_ce, 32'(m_hit(addr)));
        if (m_hit(addr)) check("resume_data", o_data, mem_word(addr));
        if (!drop_ce && flush_beat < 0) check("latency", cycles, 32'(3 + LW + ack_delay + gaps));
        i_ce = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        i_rst       = 1'b1;
        i_ce        = 1'b0;
        i_flush     = 1'b0;
        i_addr      = '0;
        i_mem_ack   = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
        bmem[32'h0] = 32'h13;
        bmem[32'h4] = 32'h01;
        bmem[32'h8] = 32'h02;
        bmem[32'hC] = 32'h03;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst_mem_req", o_mem_req, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_data", o_data, 0);
        i_ce = 1'b1;
        #1;
        check("rst_cpu_ce", o_cpu_ce, 0);
        i_ce = 1'b0;

        // Cold miss on line 0, then a hit on word 2 of the same line.
        fetch(32'h0, 0, 0, -1, -1, 1'b0);
        fetch(32'h8, 0, 0, -1, -1, 1'b0);
        check("line0_word2", mem_word(32'h8), 32'h02);
        // Conflict on index 0 evicts line 0.
        fetch(32'h400, 0, 0, -1, -1, 1'b0);
        fetch(32'h0, 0, 0, -1, -1, 1'b0);
        // Flush in IDLE with line 0 cached, then refetch misses.
        flush_idle(32'h0);
        fetch(32'h0, 0, 0, -1, -1, 1'b0);
        // Flush during beat 2: the filled line is not validated.
        fetch(32'h10, 0, 0, 2, -1, 1'b0);
        fetch(32'h10, 0, 0, -1, -1, 1'b0);
        // Reset during beat 2 clears every line.
        fetch(32'h20, 0, 0, -1, 2, 1'b0);
        fetch(32'h10, 0, 0, -1, -1, 1'b0);
        // Memory holds off the ack for 5 cycles.
        fetch(32'h30, 5, 0, -1, -1, 1'b0);
        // CPU enable low while the fill runs.
        fetch(32'h44, 1, 1, -1, -1, 1'b1);

        repeat (80) begin
            addr = (32'($urandom_range(3)) << 10) | (32'($urandom_range(7)) << 4)
                 | (32'($urandom_range(3)) << 2);
            if ($urandom_range(15) == 0) begin
                flush_idle(addr);
            end else begin
                fetch(addr, int'($urandom_range(3)), int'($urandom_range(2)),
                      ($urandom_range(9) == 0) ? int'($urandom_range(LW - 1)) : -1,
                      -1, ($urandom_range(7) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
